mem_rd_responder: RTL and testbench
===================================

MEM_RD_RESPONDER -- requirements
Module: mem_rd_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 64, meaning word width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rd_req_val  input  1  read request valid.
REQ-006 SHALL have port rd_req_addr  input  ADDR_W  read word address.
REQ-007 SHALL have port rd_req_rdy  output  1  request accepted when val & rdy.
REQ-008 SHALL have port rd_resp_val  output  1  response data valid.
REQ-009 SHALL have port rd_resp_data  output  DATA_W  read data.
REQ-010 SHALL have port rd_resp_rdy  input  1  consumer accepts response when val & rdy.
REQ-011 SHALL have port wr_req_val  input  1  write valid.
REQ-012 SHALL have port wr_req_addr  input  ADDR_W  write word address.
REQ-013 SHALL have port wr_req_data  input  DATA_W  write data.
REQ-014 SHALL have port wr_req_rdy  output  1  tied 1 outside reset; writes always accepted.

Function
REQ-015 SHALL hold a simple-dual-port RAM: one write, one synchronous read per cycle.
REQ-016 SHALL commit a write at the edge ending the cycle with wr_req_val & wr_req_rdy.
REQ-017 SHALL return old data (read-first) when a read and a write hit the same address in the same cycle.
REQ-018 SHALL pipeline reads: accept cycle N -> RAM stage valid in N+1 -> pushed into response FIFO at end of N+1 -> rd_resp_val earliest in N+2 (latency 2).
REQ-019 SHALL buffer responses in a 3-entry FIFO, in request order; rd_resp_data = FIFO head.
REQ-020 SHALL drive rd_req_rdy from registers only: rdy = (fifo_count + ram_stage_valid) < 3; no combinational path from rd_resp_rdy.
REQ-021 SHALL sustain one request and one response per cycle when rd_resp_rdy is held high.
REQ-022 SHALL, on simultaneous push and pop, leave fifo_count unchanged; pop from a 1-entry FIFO with push presents the pushed word next cycle.
REQ-023 SHALL never drop or duplicate a response; push into a full FIFO is impossible by REQ-020 and SHALL be flagged by an assertion.
REQ-024 SHALL hold rd_resp_val and rd_resp_data stable while rd_resp_val & ~rd_resp_rdy.
REQ-025 SHALL wrap FIFO read/write pointers modulo 3.

Reset
REQ-026 SHALL, during rst, drive rd_req_rdy=0, rd_resp_val=0, wr_req_rdy=0, and ignore all inputs.
REQ-027 SHALL clear fifo_count, pointers and ram_stage_valid; in-flight and buffered responses are discarded.
REQ-028 SHALL NOT reset RAM contents; reads return previously written data after rst deasserts.
REQ-029 SHALL assert rd_req_rdy=1, wr_req_rdy=1 the first cycle after rst deasserts.

Structure
REQ-030 SHALL place RESP_FIFO_DEPTH=3 in shared package mem_pkg.
REQ-031 SHALL implement the response buffer as sub-module mem_rd_resp_fifo (parameters DATA_W, depth 3).

Verification
REQ-032 Write 0xA5 to addr 3, read addr 3 with rd_resp_rdy=1 -> rd_resp_val high exactly 2 cycles after accept, data 0xA5.
REQ-033 Back-to-back reads addr 0..15, rd_resp_rdy=1 -> 16 in-order responses on 16 consecutive cycles, rd_req_rdy never low.
REQ-034 rd_resp_rdy=0, continuous requests -> exactly 3 accepted then rd_req_rdy=0; release -> 3 responses in order, then acceptance resumes.
REQ-035 Same-cycle write 0x55 and read to addr 7 holding 0x11 -> response 0x11; next read of addr 7 -> 0x55.
REQ-036 Assert rst with 2 buffered + 1 in-flight -> no rd_resp_val after reset; next read returns correct RAM data.
REQ-037 Random rd_resp_rdy toggling, 1000 reads vs scoreboard -> zero mismatches, data stable under stall.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the memory read-responder slice.
package mem_pkg;

  // Number of read responses that can be buffered ahead of the consumer.
  localparam int RESP_FIFO_DEPTH = 3;
  localparam int FIFO_PTR_W      = 2;
  localparam int FIFO_CNT_W      = 2;

  typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;
  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

  // Advance a FIFO pointer, wrapping at the (non power-of-two) depth.
  function automatic fifo_ptr_t fifo_ptr_inc(input fifo_ptr_t ptr);
    return (ptr == fifo_ptr_t'(RESP_FIFO_DEPTH - 1)) ? fifo_ptr_t'(0) : ptr + fifo_ptr_t'(1);
  endfunction

endpackage

// File: rtl/mem_rd_resp_fifo.sv
// Three-entry response FIFO. Head word is presented combinationally on o_data.
// Handshake: a word leaves when o_val & i_pop at a rising edge; i_push is
// unconditional from the producer, which guarantees space via o_count.
module mem_rd_resp_fifo
  import mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_val,
  output logic [DATA_W-1:0] o_data,
  output fifo_cnt_t         o_count
);

  logic [DATA_W-1:0] r_mem [RESP_FIFO_DEPTH];
  fifo_ptr_t         r_wr_ptr;
  fifo_ptr_t         r_rd_ptr;
  fifo_cnt_t         r_count;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_full  = (r_count == fifo_cnt_t'(RESP_FIFO_DEPTH));
  assign w_pop   = i_pop & (r_count != '0) & ~rst;
  // A push into a full FIFO without a pop is dropped rather than corrupting the head.
  assign w_push  = i_push & ~rst & (~w_full | w_pop);

  assign o_val   = (r_count != '0) & ~rst;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage write; contents need no reset because r_count gates validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= fifo_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= fifo_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + fifo_cnt_t'(1);
        2'b01:   r_count <= r_count - fifo_cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The producer's credit check must make an overflowing push impossible.
  always_ff @(posedge clk) begin
    if (!rst && i_push && !w_pop) begin
      assert (!w_full);
    end
  end

endmodule

// File: rtl/mem_rd_responder.sv
// Simple-dual-port RAM with a two-cycle read pipeline and a buffered
// response stream.
// Handshake: every channel transfers when val & rdy are both high at a rising
// clk edge; rdy never depends combinationally on the same channel's val, and
// rd_req_rdy depends only on registered state (plus rst).
module mem_rd_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_val,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_req_rdy,
  output logic              rd_resp_val,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              rd_resp_rdy,
  input  logic              wr_req_val,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              wr_req_rdy
);

  logic [DATA_W-1:0] r_ram [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_stage_vld;
  logic              w_rd_acc;
  logic              w_wr_acc;
  fifo_cnt_t         w_fifo_count;
  logic [2:0]        w_occupancy;

  // Credits: buffered responses plus the one possibly in the RAM stage.
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_stage_vld};
  assign rd_req_rdy  = ~rst & (w_occupancy < 3'(RESP_FIFO_DEPTH));
  assign wr_req_rdy  = ~rst;

  assign w_rd_acc    = rd_req_val & rd_req_rdy;
  assign w_wr_acc    = wr_req_val & wr_req_rdy;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_ram[wr_req_addr] <= wr_req_data;
    end
  end

  // Synchronous read port; non-blocking update gives read-first on collisions.
  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_rd_data <= r_ram[rd_req_addr];
    end
  end

  // RAM stage valid flag; cleared on reset so in-flight reads are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_vld <= 1'b0;
    end else begin
      r_stage_vld <= w_rd_acc;
    end
  end

  mem_rd_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_stage_vld),
    .i_push_data (r_rd_data),
    .i_pop       (rd_resp_rdy),
    .o_val       (rd_resp_val),
    .o_data      (rd_resp_data),
    .o_count     (w_fifo_count)
  );

endmodule

// File: tb/tb_mem_rd_responder.sv
// Directed and random bench for mem_rd_responder.
module tb_mem_rd_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              rd_req_val = 1'b0;
  logic [ADDR_W-1:0] rd_req_addr = '0;
  logic              rd_req_rdy;
  logic              rd_resp_val;
  logic [DATA_W-1:0] rd_resp_data;
  logic              rd_resp_rdy = 1'b0;
  logic              wr_req_val = 1'b0;
  logic [ADDR_W-1:0] wr_req_addr = '0;
  logic [DATA_W-1:0] wr_req_data = '0;
  logic              wr_req_rdy;

  mem_rd_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_val   (rd_req_val),
    .rd_req_addr  (rd_req_addr),
    .rd_req_rdy   (rd_req_rdy),
    .rd_resp_val  (rd_resp_val),
    .rd_resp_data (rd_resp_data),
    .rd_resp_rdy  (rd_resp_rdy),
    .wr_req_val   (wr_req_val),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_rdy   (wr_req_rdy)
  );

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] mem_model [2**ADDR_W];
  logic [DATA_W-1:0] exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: samples at negedge, mirroring transfers that happen at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      check("rst_resp_val", {63'b0, rd_resp_val}, 64'd0);
      check("rst_rd_rdy",   {63'b0, rd_req_rdy},  64'd0);
      check("rst_wr_rdy",   {63'b0, wr_req_rdy},  64'd0);
    end else begin
      if (prev_stall) begin
        check("stall_val",  {63'b0, rd_resp_val}, 64'd1);
        check("stall_data", rd_resp_data, prev_data);
      end
      if (rd_resp_val && rd_resp_rdy) begin
        if (exp_q.size() == 0) check("spurious_resp", 64'd1, 64'd0);
        else                   check("resp_data", rd_resp_data, exp_q.pop_front());
      end
      if (rd_req_val && rd_req_rdy) exp_q.push_back(mem_model[rd_req_addr]);
      if (wr_req_val && wr_req_rdy) mem_model[wr_req_addr] = wr_req_data;
      prev_stall = rd_resp_val && !rd_resp_rdy;
      prev_data  = rd_resp_data;
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle; returns just after the following negedge (monitor done).
  task automatic cyc_drive(input logic rv, input logic [ADDR_W-1:0] ra,
                           input logic wv, input logic [ADDR_W-1:0] wa,
                           input logic [DATA_W-1:0] wd, input logic rr);
    @(posedge clk);
    #1;
    rd_req_val  = rv;
    rd_req_addr = ra;
    wr_req_val  = wv;
    wr_req_addr = wa;
    wr_req_data = wd;
    rd_resp_rdy = rr;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    cyc_drive(1'b0, '0, 1'b0, '0, '0, rr);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cyc_drive(1'b0, '0, 1'b1, a, d, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int issued;

    // Reset for three cycles.
    for (int i = 0; i < 3; i++) idle(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_rd_rdy",   {63'b0, rd_req_rdy},  64'd1);
    check("post_rst_wr_rdy",   {63'b0, wr_req_rdy},  64'd1);
    check("post_rst_resp_val", {63'b0, rd_resp_val}, 64'd0);

    // Preload every word so any address can be read.
    for (int a = 0; a < 2**ADDR_W; a++) wr(ADDR_W'(a), {$urandom, $urandom});

    // Basic latency: write 0xA5 to 3, read 3.
    wr(8'd3, 64'hA5);
    cyc_drive(1'b1, 8'd3, 1'b0, '0, '0, 1'b1);
    check("lat_accept", {63'b0, rd_req_rdy}, 64'd1);
    idle(1'b1);
    check("lat_n1_val", {63'b0, rd_resp_val}, 64'd0);
    idle(1'b1);
    check("lat_n2_val",  {63'b0, rd_resp_val}, 64'd1);
    check("lat_n2_data", rd_resp_data, 64'hA5);
    idle(1'b1);

    // Back-to-back reads 0..15 with consumer always ready.
    for (int c = 0; c < 18; c++) begin
      cyc_drive(c < 16, ADDR_W'(c), 1'b0, '0, '0, 1'b1);
      if (c < 16) check("b2b_rdy", {63'b0, rd_req_rdy}, 64'd1);
      check("b2b_val", {63'b0, rd_resp_val}, {63'b0, c >= 2});
    end
    idle(1'b1);

    // Backpressure: exactly three requests accepted.
    for (int c = 0; c < 6; c++) begin
      cyc_drive(1'b1, ADDR_W'(20 + c), 1'b0, '0, '0, 1'b0);
      check("bp_rdy", {63'b0, rd_req_rdy},  {63'b0, c < 3});
      check("bp_val", {63'b0, rd_resp_val}, {63'b0, c >= 2});
    end
    cyc_drive(1'b1, 8'd40, 1'b0, '0, '0, 1'b1);
    check("release_rdy0", {63'b0, rd_req_rdy},  64'd0);
    check("release_val",  {63'b0, rd_resp_val}, 64'd1);
    check("release_head", rd_resp_data, mem_model[20]);
    cyc_drive(1'b1, 8'd41, 1'b0, '0, '0, 1'b1);
    check("release_rdy1", {63'b0, rd_req_rdy},  64'd1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Read-first collision on address 7.
    wr(8'd7, 64'h11);
    cyc_drive(1'b1, 8'd7, 1'b1, 8'd7, 64'h55, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("coll_val",  {63'b0, rd_resp_val}, 64'd1);
    check("coll_old",  rd_resp_data, 64'h11);
    cyc_drive(1'b1, 8'd7, 1'b0, '0, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("coll_new",  rd_resp_data, 64'h55);
    idle(1'b1);

    // Reset with two buffered responses and one in flight.
    for (int c = 0; c < 3; c++) cyc_drive(1'b1, ADDR_W'(30 + c), 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    check("pre_rst_val", {63'b0, rd_resp_val}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd_resp_rdy = 1'b1;
    idle(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("post_rst_no_resp", {63'b0, rd_resp_val}, 64'd0);
    end
    cyc_drive(1'b1, 8'd3, 1'b0, '0, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("post_rst_read_val",  {63'b0, rd_resp_val}, 64'd1);
    check("post_rst_read_data", rd_resp_data, 64'hA5);
    idle(1'b1);

    // Random consumer stalls with 1000 reads and sprinkled writes.
    issued = 0;
    for (int c = 0; c < 20000 && issued < 1000; c++) begin
      logic rv;
      rv = ($urandom_range(0, 3) != 0);
      cyc_drive(rv, ADDR_W'($urandom_range(0, 2**ADDR_W - 1)),
                ($urandom_range(0, 3) == 0), ADDR_W'($urandom_range(0, 2**ADDR_W - 1)),
                {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      if (rv && rd_req_rdy) issued++;
    end
    check("rand_issued", 64'(issued), 64'd1000);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("final_idle_val", {63'b0, rd_resp_val}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
